// File: rtl/otter_control_fsm.sv
// Multicycle control sequencer for the OTTER core: steps each instruction through
// FETCH/EXEC(/WB), enters TRAP on a retiring edge with INTR, and counts retirements.
module otter_control_fsm #(
  parameter int INSTRET_W = 32
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [6:0]           OPCODE,
  input  logic [2:0]           FUNC3,
  input  logic                 INTR,
  input  logic                 DMEM_VALID,
  output logic                 PC_WRITE,
  output logic                 PC_RST,
  output logic                 REG_WRITE,
  output logic                 MEM_RDEN1,
  output logic                 MEM_RDEN2,
  output logic                 MEM_WE2,
  output logic                 CSR_WE,
  output logic                 INT_TAKEN,
  output logic                 MRET_EXEC,
  output logic [INSTRET_W-1:0] INSTRET
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_TRAP  = 3'd4
  } state_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_e               state_q, state_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;

  logic pc_write, pc_rst, reg_write, mem_rden1, mem_rden2, mem_we2, csr_we;
  logic int_taken, mret_exec;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d   = state_q;
    pc_write  = 1'b0;
    pc_rst    = 1'b0;
    reg_write = 1'b0;
    mem_rden1 = 1'b0;
    mem_rden2 = 1'b0;
    mem_we2   = 1'b0;
    csr_we    = 1'b0;
    int_taken = 1'b0;
    mret_exec = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        pc_rst  = 1'b1;
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        mem_rden1 = 1'b1;
        state_d   = ST_EXEC;
      end

      ST_EXEC: begin
        pc_write = 1'b1;
        unique case (OPCODE)
          OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_REG: reg_write = 1'b1;
          OP_BRANCH: ;
          OP_STORE:  mem_we2 = 1'b1;
          OP_LOAD: begin
            // Loads retire in WB once the data handshake completes.
            pc_write  = 1'b0;
            mem_rden2 = 1'b1;
          end
          OP_SYSTEM: begin
            if (FUNC3 == 3'b000) begin
              mret_exec = 1'b1;
            end else begin
              csr_we    = 1'b1;
              reg_write = 1'b1;
            end
          end
          default: ;  // illegal opcode: skipped, PC still advances
        endcase
        if (OPCODE == OP_LOAD) state_d = ST_WB;
        else                   state_d = INTR ? ST_TRAP : ST_FETCH;
      end

      ST_WB: begin
        if (DMEM_VALID) begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          state_d   = INTR ? ST_TRAP : ST_FETCH;
        end
      end

      ST_TRAP: begin
        int_taken = 1'b1;
        pc_write  = 1'b1;
        state_d   = ST_FETCH;
      end

      default: state_d = ST_INIT;
    endcase

    // Trap entry loads the PC but retires nothing.
    instret_d = instret_q + INSTRET_W'(pc_write && (state_q != ST_TRAP));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= ST_INIT;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign PC_WRITE  = pc_write;
  assign PC_RST    = pc_rst;
  assign REG_WRITE = reg_write;
  assign MEM_RDEN1 = mem_rden1;
  assign MEM_RDEN2 = mem_rden2;
  assign MEM_WE2   = mem_we2;
  assign CSR_WE    = csr_we;
  assign INT_TAKEN = int_taken;
  assign MRET_EXEC = mret_exec;
  assign INSTRET   = instret_q;

endmodule

// File: tb/tb_otter_control_fsm.sv
// Directed-vector bench for otter_control_fsm; a 4-bit-counter instance shares the
// stimulus so counter wrap is reached within a short run.
module tb_otter_control_fsm;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [6:0] OPCODE;
  logic [2:0] FUNC3;
  logic       INTR;
  logic       DMEM_VALID;

  logic        PC_WRITE, PC_RST, REG_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2;
  logic        CSR_WE, INT_TAKEN, MRET_EXEC;
  logic [31:0] INSTRET;

  logic       w_pc_write, w_pc_rst, w_reg_write, w_mem_rden1, w_mem_rden2, w_mem_we2;
  logic       w_csr_we, w_int_taken, w_mret_exec;
  logic [3:0] w_instret;

  otter_control_fsm #(.INSTRET_W(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .OPCODE(OPCODE), .FUNC3(FUNC3), .INTR(INTR),
    .DMEM_VALID(DMEM_VALID), .PC_WRITE(PC_WRITE), .PC_RST(PC_RST),
    .REG_WRITE(REG_WRITE), .MEM_RDEN1(MEM_RDEN1), .MEM_RDEN2(MEM_RDEN2),
    .MEM_WE2(MEM_WE2), .CSR_WE(CSR_WE), .INT_TAKEN(INT_TAKEN),
    .MRET_EXEC(MRET_EXEC), .INSTRET(INSTRET)
  );

  otter_control_fsm #(.INSTRET_W(4)) dut_w (
    .CLK(CLK), .RST_N(RST_N), .OPCODE(OPCODE), .FUNC3(FUNC3), .INTR(INTR),
    .DMEM_VALID(DMEM_VALID), .PC_WRITE(w_pc_write), .PC_RST(w_pc_rst),
    .REG_WRITE(w_reg_write), .MEM_RDEN1(w_mem_rden1), .MEM_RDEN2(w_mem_rden2),
    .MEM_WE2(w_mem_we2), .CSR_WE(w_csr_we), .INT_TAKEN(w_int_taken),
    .MRET_EXEC(w_mret_exec), .INSTRET(w_instret)
  );

  always #5 CLK = ~CLK;

  // Output bundle: {PC_WRITE, PC_RST, REG_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2, CSR_WE, INT_TAKEN, MRET_EXEC}
  localparam logic [8:0] O_NONE = 9'h000;
  localparam logic [8:0] O_PCW  = 9'h100;
  localparam logic [8:0] O_PRST = 9'h080;
  localparam logic [8:0] O_RW   = 9'h040;
  localparam logic [8:0] O_RD1  = 9'h020;
  localparam logic [8:0] O_RD2  = 9'h010;
  localparam logic [8:0] O_WE2  = 9'h008;
  localparam logic [8:0] O_CSR  = 9'h004;
  localparam logic [8:0] O_INT  = 9'h002;
  localparam logic [8:0] O_MRET = 9'h001;

  logic [8:0] outs;
  assign outs = {PC_WRITE, PC_RST, REG_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2,
                 CSR_WE, INT_TAKEN, MRET_EXEC};

  int n_vec = 0;
  int n_err = 0;
  int exp_ir = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 2-3 ns after the edge.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // Called in FETCH; runs one non-load instruction through EXEC (and TRAP if intr).
  task automatic run_op(input string tag, input logic [6:0] op, input logic [2:0] f3,
                        input logic intr, input logic [8:0] exp_exec);
    check({tag, "_fetch"}, 32'(outs), 32'(O_RD1));
    OPCODE = op;
    FUNC3  = f3;
    tick();
    INTR = intr;
    #1;
    check({tag, "_exec"}, 32'(outs), 32'(exp_exec));
    tick();
    INTR = 1'b0;
    exp_ir++;
    #1;
    if (intr) begin
      check({tag, "_trap"}, 32'(outs), 32'(O_INT | O_PCW));
      tick();
      #1;
    end
  endtask

  initial begin
    RST_N = 1'b0; OPCODE = 7'b0110011; FUNC3 = 3'b000; INTR = 1'b0; DMEM_VALID = 1'b0;

    // Reset held for 3 cycles, then released.
    repeat (3) tick();
    #1;
    check("rst_outs", 32'(outs), 32'(O_PRST));
    check("rst_instret", INSTRET, 32'd0);
    RST_N = 1'b1;
    #1;
    check("rel_pcrst", 32'(outs), 32'(O_PRST));
    tick();
    #1;
    check("rel_fetch", 32'(outs), 32'(O_RD1));
    check("rel_instret", INSTRET, 32'd0);

    // Instruction mix: OP, BRANCH, STORE.
    run_op("op",     7'b0110011, 3'b000, 1'b0, O_RW | O_PCW);
    run_op("branch", 7'b1100011, 3'b000, 1'b0, O_PCW);
    run_op("store",  7'b0100011, 3'b010, 1'b0, O_WE2 | O_PCW);
    check("mix_instret", INSTRET, 32'd3);

    // Load with DMEM_VALID low for 2 WB cycles.
    check("ld_fetch", 32'(outs), 32'(O_RD1));
    OPCODE = 7'b0000011;
    tick(); #1;
    check("ld_exec", 32'(outs), 32'(O_RD2));
    tick(); #1;
    check("ld_wb_wait1", 32'(outs), 32'(O_NONE));
    INTR = 1'b1;  // asserted while waiting, dropped before retirement
    tick(); #1;
    check("ld_wb_wait2", 32'(outs), 32'(O_NONE));
    check("ld_instret_wait", INSTRET, 32'd3);
    INTR = 1'b0;
    tick();
    DMEM_VALID = 1'b1;
    #1;
    check("ld_wb_done", 32'(outs), 32'(O_RW | O_PCW));
    tick();
    DMEM_VALID = 1'b0;
    exp_ir++;
    #1;
    check("ld_instret", INSTRET, 32'(exp_ir));

    // Interrupt taken at EXEC of OP-IMM: one TRAP cycle, one retirement.
    run_op("intr", 7'b0010011, 3'b000, 1'b1, O_RW | O_PCW);
    check("intr_instret", INSTRET, 32'(exp_ir));

    // INTR seen only in FETCH is ignored.
    INTR = 1'b1;
    check("ifetch_fetch", 32'(outs), 32'(O_RD1));
    OPCODE = 7'b0110111;
    tick();
    INTR = 1'b0;
    #1;
    check("ifetch_exec", 32'(outs), 32'(O_RW | O_PCW));
    tick(); exp_ir++; #1;

    // SYSTEM (CSR, mret), illegal, mret with INTR.
    run_op("csr",     7'b1110011, 3'b001, 1'b0, O_CSR | O_RW | O_PCW);
    run_op("mret",    7'b1110011, 3'b000, 1'b0, O_MRET | O_PCW);
    run_op("illegal", 7'b1111111, 3'b000, 1'b0, O_PCW);
    check("sys_instret", INSTRET, 32'(exp_ir));
    run_op("mret_intr", 7'b1110011, 3'b000, 1'b1, O_MRET | O_PCW);

    // Load retiring with INTR -> TRAP.
    OPCODE = 7'b0000011;
    tick(); tick();
    DMEM_VALID = 1'b1; INTR = 1'b1;
    #1;
    check("ldi_wb", 32'(outs), 32'(O_RW | O_PCW));
    tick();
    DMEM_VALID = 1'b0; INTR = 1'b0; exp_ir++;
    #1;
    check("ldi_trap", 32'(outs), 32'(O_INT | O_PCW));
    tick(); #1;
    check("ldi_instret", INSTRET, 32'(exp_ir));

    // Reset while a load waits in WB.
    OPCODE = 7'b0000011;
    tick(); tick();
    RST_N = 1'b0;
    #1;
    check("rstld_wb", 32'(outs), 32'(O_NONE));
    tick(); #1;
    check("rstld_init", 32'(outs), 32'(O_PRST));
    check("rstld_instret", INSTRET, 32'd0);
    RST_N = 1'b1;
    exp_ir = 0;
    tick(); #1;

    // Counter wrap on the 4-bit instance.
    for (int i = 0; i < 17; i++) begin
      run_op("wrap", 7'b0110011, 3'b000, 1'b0, O_RW | O_PCW);
      if (i == 14) check("wrap_w_15", 32'(w_instret), 32'h0000000F);
      if (i == 15) check("wrap_w_0", 32'(w_instret), 32'h00000000);
    end
    check("wrap_w_1", 32'(w_instret), 32'h00000001);
    check("wrap_main", INSTRET, 32'd17);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
